// File: rtl/cpu_clk_ctrl_if.sv
// Signal bundle between the clock divider/front panel and the CPU clock controller.
// The slave modport is the controller; the master side drives the panel inputs.
interface cpu_clk_ctrl_if #(
   parameter int BURST_W = 8
);
   logic               slow_clk;
   logic               run_sw;
   logic               step_btn;
   logic               burst_go;
   logic [BURST_W-1:0] burst_count;
   logic               halt_req;
   logic               cpu_ce;
   logic [1:0]         state;
   logic               busy;
   logic [31:0]        cycle_count;

   modport master (
      output slow_clk, run_sw, step_btn, burst_go, burst_count, halt_req,
      input  cpu_ce, state, busy, cycle_count
   );

   modport slave (
      input  slow_clk, run_sw, step_btn, burst_go, burst_count, halt_req,
      output cpu_ce, state, busy, cycle_count
   );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Turns the divided slow clock into single-cycle CPU clock enables in free-run,
// debounced single-step or counted-burst mode, with CPU halt and run lockout.
module cpu_clk_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BURST_W         = 8
) (
   input logic           clk_in,
   input logic           reset,
   cpu_clk_ctrl_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   state_t             state_r, state_n;
   logic [BURST_W-1:0] remaining_r, remaining_n;
   logic               ce_n;
   logic               lock_set_s;
   logic               run_lock_r;
   logic               cpu_ce_r;
   logic               busy_r;
   logic [31:0]        cycle_count_r;
   logic               slow_q_r;
   logic               tick_s;
   logic               run_meta_r, run_s_r;
   logic               step_meta_r, step_s_r;
   logic               step_db_r, step_db_q_r;
   logic [DB_W-1:0]    db_cnt_r;
   logic               step_press_s;

   // slow_q resets high so a slow_clk already high at release gives no tick
   assign tick_s       = bus.slow_clk & ~slow_q_r;
   assign step_press_s = step_db_r & ~step_db_q_r;

   // Edge detector and two-flop synchronisers for the asynchronous panel inputs
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         slow_q_r    <= 1'b1;
         run_meta_r  <= 1'b0;
         run_s_r     <= 1'b0;
         step_meta_r <= 1'b0;
         step_s_r    <= 1'b0;
      end else begin
         slow_q_r    <= bus.slow_clk;
         run_meta_r  <= bus.run_sw;
         run_s_r     <= run_meta_r;
         step_meta_r <= bus.step_btn;
         step_s_r    <= step_meta_r;
      end
   end

   // Step button debounce: level follows only after a full run of differing samples
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         step_db_r   <= 1'b0;
         step_db_q_r <= 1'b0;
         db_cnt_r    <= {DB_W{1'b0}};
      end else begin
         step_db_q_r <= step_db_r;
         if (step_s_r != step_db_r) begin
            if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               step_db_r <= step_s_r;
               db_cnt_r  <= {DB_W{1'b0}};
            end else begin
               db_cnt_r  <= db_cnt_r + DB_W'(1);
            end
         end else begin
            db_cnt_r <= {DB_W{1'b0}};
         end
      end
   end

   // Mode next-state and clock-enable decision; halt beats run drop beats tick
   always_comb begin
      state_n     = state_r;
      remaining_n = remaining_r;
      ce_n        = 1'b0;
      lock_set_s  = 1'b0;
      case (state_r)
         ST_HALT: begin
            if (run_s_r && !run_lock_r) begin
               state_n = ST_RUN;
            end else if (step_press_s) begin
               state_n = ST_STEP;
            end else if (bus.burst_go && (bus.burst_count != {BURST_W{1'b0}})) begin
               state_n     = ST_BURST;
               remaining_n = bus.burst_count;
            end else begin
               state_n = ST_HALT;
            end
         end
         ST_RUN: begin
            if (bus.halt_req) begin
               state_n    = ST_HALT;
               lock_set_s = 1'b1;
            end else if (!run_s_r) begin
               state_n = ST_HALT;
            end else if (tick_s) begin
               ce_n = 1'b1;
            end else begin
               state_n = ST_RUN;
            end
         end
         ST_STEP: begin
            if (bus.halt_req) begin
               state_n = ST_HALT;
            end else if (tick_s) begin
               ce_n    = 1'b1;
               state_n = ST_HALT;
            end else begin
               state_n = ST_STEP;
            end
         end
         ST_BURST: begin
            if (bus.halt_req) begin
               state_n     = ST_HALT;
               remaining_n = {BURST_W{1'b0}};
            end else if (tick_s) begin
               ce_n        = 1'b1;
               remaining_n = remaining_r - BURST_W'(1);
               if (remaining_r == BURST_W'(1)) begin
                  state_n = ST_HALT;
               end else begin
                  state_n = ST_BURST;
               end
            end else begin
               state_n = ST_BURST;
            end
         end
         default: begin
            state_n     = ST_HALT;
            remaining_n = {BURST_W{1'b0}};
         end
      endcase
   end

   // Mode register, registered outputs and the pulse counter
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_r       <= ST_HALT;
         remaining_r   <= {BURST_W{1'b0}};
         cpu_ce_r      <= 1'b0;
         busy_r        <= 1'b0;
         cycle_count_r <= 32'd0;
      end else begin
         state_r     <= state_n;
         remaining_r <= remaining_n;
         cpu_ce_r    <= ce_n;
         busy_r      <= (state_n != ST_HALT);
         if (ce_n) begin
            cycle_count_r <= cycle_count_r + 32'd1;
         end else begin
            cycle_count_r <= cycle_count_r;
         end
      end
   end

   // Run lockout: armed by a CPU halt out of RUN, disarmed by opening the run switch
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         run_lock_r <= 1'b0;
      end else if (!run_s_r) begin
         run_lock_r <= 1'b0;
      end else if (lock_set_s) begin
         run_lock_r <= 1'b1;
      end else begin
         run_lock_r <= run_lock_r;
      end
   end

   assign bus.cpu_ce      = cpu_ce_r;
   assign bus.state       = state_r;
   assign bus.busy        = busy_r;
   assign bus.cycle_count = cycle_count_r;
endmodule
